// File: rtl/neuro_uart_rx_pkg.sv
// neurocore_pkg: shared UART receiver state encoding, parity modes and log bit map.
package neurocore_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  localparam int LOG_FRAME = 0;
  localparam int LOG_PARITY = 1;
  localparam int LOG_OVERRUN = 2;
  localparam int LOG_GLITCH = 3;
  localparam int LOG_BUSY = 4;
  localparam int LOG_VALID = 5;
  localparam int LOG_CNT_LSB = 6;
endpackage

// File: rtl/neuro_uart_rx_if.sv
// neuro_uart_rx_if: received-byte handshake plus status log between receiver and loader.
interface neuro_uart_rx_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic log_clr;
  logic [7:0] log_out;
  modport master(output rx_data, rx_valid, log_out, input rx_ready, log_clr);
  modport slave(input rx_data, rx_valid, log_out, output rx_ready, log_clr);
endinterface

// File: rtl/neuro_uart_rx_sync2.sv
// neuro_sync2: two-flop synchroniser for the idle-high RXD pad, resets to 1.
module neuro_sync2 (
  input  logic CLK,
  input  logic RESET,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/neuro_uart_rx.sv
// neuro_uart_rx: UART frame deserialiser with valid/ready delivery and sticky status log.
module neuro_uart_rx
  import neurocore_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = PARITY_NONE
) (
  input logic CLK,
  input logic RESET,
  input logic RXD,
  neuro_uart_rx_if.master rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_START = START;
  localparam logic [2:0] ST_DATA = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP = STOP;
  logic rxs;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic perr_q, perr_d, dlv_q, dlv_d, valid_q, valid_d, load;
  logic [3:0] sticky_q, sticky_d, ev;
  logic [1:0] fcnt_q, fcnt_d;
  neuro_sync2 u_sync (.CLK(CLK), .RESET(RESET), .d_i(RXD), .q_o(rxs));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    perr_d = perr_q;
    dlv_d = 1'b0;
    ev = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = ST_START;
          perr_d = 1'b0;
        end
      end
      ST_START:
        if (cnt_q == HALF) begin
          cnt_d = '0;
          idx_d = '0;
          ev[LOG_GLITCH] = rxs;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end
      ST_DATA:
        if (cnt_q == FULL) begin
          cnt_d = '0;
          shift_d[idx_q] = rxs;
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'(DATA_BITS - 1))
            state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      ST_PARITY:
        if (cnt_q == FULL) begin
          cnt_d = '0;
          perr_d = rxs != ((^shift_q) ^ (PARITY_MODE == PARITY_ODD));
          state_d = ST_STOP;
        end
      ST_STOP:
        // Leave at mid stop bit so the next start edge is caught early
        if (cnt_q == FULL) begin
          cnt_d = '0;
          state_d = ST_IDLE;
          ev[LOG_FRAME] = !rxs;
          ev[LOG_PARITY] = rxs & perr_q;
          dlv_d = rxs & !perr_q;
        end
      default: state_d = ST_IDLE;
    endcase
    load = dlv_q & (!valid_q | rx.rx_ready);
    ev[LOG_OVERRUN] = dlv_q & !load;
    data_d = load ? shift_q : data_q;
    valid_d = load | (valid_q & !rx.rx_ready);
    sticky_d = (rx.log_clr ? 4'b0 : sticky_q) | ev;
    fcnt_d = (rx.log_clr ? 2'b0 : fcnt_q) + 2'(load);
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      dlv_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      sticky_q <= '0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      dlv_q <= dlv_d;
      data_q <= data_d;
      valid_q <= valid_d;
      sticky_q <= sticky_d;
      fcnt_q <= fcnt_d;
    end
  assign rx.rx_data = data_q;
  assign rx.rx_valid = valid_q;
  assign rx.log_out = {fcnt_q, valid_q, state_q != ST_IDLE, sticky_q};
endmodule

// File: tb/tb_neuro_uart_rx.sv
// tb_neuro_uart_rx: directed frames against an 8N1 receiver and an 8E1 receiver.
module tb_neuro_uart_rx;
  logic CLK = 0, RESET = 0, rxd_a = 1, rxd_b = 1;
  int total = 0, bad = 0, cyc = 0, t0 = 0, t_valid = 0, a_got = 0, b_got = 0;
  logic [7:0] a_data = 0, b_data = 0;
  logic a_prev = 0;
  neuro_uart_rx_if #(.DATA_BITS(8)) ia ();
  neuro_uart_rx_if #(.DATA_BITS(8)) ib ();
  neuro_uart_rx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(0)) dut_a (
    .CLK(CLK), .RESET(RESET), .RXD(rxd_a), .rx(ia));
  neuro_uart_rx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .RXD(rxd_b), .rx(ib));
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ia.rx_valid && ia.rx_ready) begin
      a_got <= a_got + 1;
      a_data <= ia.rx_data;
    end
    if (ib.rx_valid && ib.rx_ready) begin
      b_got <= b_got + 1;
      b_data <= ib.rx_data;
    end
  end
  always @(negedge CLK) begin
    if (ia.rx_valid && !a_prev) t_valid <= cyc;
    a_prev <= ia.rx_valid;
  end
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic send(input bit sel, input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) rxd_b = f[i];
      else rxd_a = f[i];
      if (i == 0) t0 = cyc + 1;
      idle(8);
    end
    if (sel) rxd_b = 1;
    else rxd_a = 1;
  endtask
  task automatic clr_a();
    ia.log_clr = 1;
    idle(1);
    ia.log_clr = 0;
  endtask
  task automatic test_reset();
    total += 4;
    if (ia.log_out !== 8'h00) begin bad++; $display("FAIL reset_log got=%h exp=00", ia.log_out); end
    if (ia.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ia.rx_valid); end
    if (ia.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", ia.rx_data); end
    if (ib.log_out !== 8'h00) begin bad++; $display("FAIL reset_log_b got=%h exp=00", ib.log_out); end
    RESET = 1;
    idle(4);
  endtask
  task automatic test_basic();
    int g = a_got;
    send(0, {1'b1, 8'hA5, 1'b0}, 10);
    idle(4);
    total += 4;
    if (a_got !== g + 1) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", a_got, g + 1); end
    if (a_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", a_data); end
    if (t_valid - t0 !== 79) begin bad++; $display("FAIL basic_latency got=%0d exp=79", t_valid - t0); end
    if (ia.log_out !== 8'h40) begin bad++; $display("FAIL basic_log got=%h exp=40", ia.log_out); end
  endtask
  task automatic test_overrun();
    int g;
    clr_a();
    ia.rx_ready = 0;
    g = a_got;
    send(0, {1'b1, 8'h3C, 1'b0}, 10);
    idle(2);
    total += 2;
    if (ia.rx_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", ia.rx_valid); end
    if (ia.rx_data !== 8'h3C) begin bad++; $display("FAIL hold_data got=%h exp=3c", ia.rx_data); end
    send(0, {1'b1, 8'hC3, 1'b0}, 10);
    idle(4);
    total += 2;
    if (ia.rx_data !== 8'h3C) begin bad++; $display("FAIL overrun_data got=%h exp=3c", ia.rx_data); end
    if (ia.log_out !== 8'h64) begin bad++; $display("FAIL overrun_log got=%h exp=64", ia.log_out); end
    ia.rx_ready = 1;
    idle(2);
    total += 3;
    if (ia.rx_valid !== 1'b0) begin bad++; $display("FAIL accept_valid got=%b exp=0", ia.rx_valid); end
    if (a_got !== g + 1) begin bad++; $display("FAIL accept_count got=%0d exp=%0d", a_got, g + 1); end
    if (a_data !== 8'h3C) begin bad++; $display("FAIL accept_data got=%h exp=3c", a_data); end
  endtask
  task automatic test_framing();
    int g = a_got;
    send(0, {1'b0, 8'h55, 1'b0}, 10);
    idle(20);
    total += 2;
    if (a_got !== g) begin bad++; $display("FAIL frame_nodeliver got=%0d exp=%0d", a_got, g); end
    if (ia.log_out[0] !== 1'b1) begin bad++; $display("FAIL frame_flag got=%b exp=1", ia.log_out[0]); end
    clr_a();
    total++;
    if (ia.log_out !== 8'h00) begin bad++; $display("FAIL log_clr got=%h exp=00", ia.log_out); end
  endtask
  task automatic test_parity();
    int g = b_got;
    send(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(4);
    total += 2;
    if (b_got !== g) begin bad++; $display("FAIL parity_nodeliver got=%0d exp=%0d", b_got, g); end
    if (ib.log_out[1] !== 1'b1) begin bad++; $display("FAIL parity_flag got=%b exp=1", ib.log_out[1]); end
    send(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(4);
    total += 2;
    if (b_got !== g + 1) begin bad++; $display("FAIL parity_count got=%0d exp=%0d", b_got, g + 1); end
    if (b_data !== 8'h07) begin bad++; $display("FAIL parity_data got=%h exp=07", b_data); end
  endtask
  task automatic test_glitch();
    int g;
    clr_a();
    g = a_got;
    rxd_a = 0;
    idle(2);
    rxd_a = 1;
    idle(20);
    total += 2;
    if (ia.log_out !== 8'h08) begin bad++; $display("FAIL glitch_log got=%h exp=08", ia.log_out); end
    if (a_got !== g) begin bad++; $display("FAIL glitch_nodeliver got=%0d exp=%0d", a_got, g); end
    send(0, {1'b1, 8'h81, 1'b0}, 10);
    idle(4);
    total += 2;
    if (a_got !== g + 1) begin bad++; $display("FAIL glitch_next_count got=%0d exp=%0d", a_got, g + 1); end
    if (a_data !== 8'h81) begin bad++; $display("FAIL glitch_next_data got=%h exp=81", a_data); end
  endtask
  task automatic test_mid_reset();
    int g;
    send(0, {1'b1, 8'hFF, 1'b0}, 4);
    RESET = 0;
    idle(2);
    total += 3;
    if (ia.log_out !== 8'h00) begin bad++; $display("FAIL midrst_log got=%h exp=00", ia.log_out); end
    if (ia.rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", ia.rx_valid); end
    if (ia.rx_data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", ia.rx_data); end
    RESET = 1;
    idle(10);
    g = a_got;
    send(0, {1'b1, 8'h12, 1'b0}, 10);
    idle(4);
    total += 3;
    if (a_got !== g + 1) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", a_got, g + 1); end
    if (a_data !== 8'h12) begin bad++; $display("FAIL midrst_next got=%h exp=12", a_data); end
    if (ia.log_out !== 8'h40) begin bad++; $display("FAIL midrst_log2 got=%h exp=40", ia.log_out); end
  endtask
  initial begin
    ia.rx_ready = 1;
    ia.log_clr = 0;
    ib.rx_ready = 1;
    ib.log_clr = 0;
    idle(3);
    test_reset();
    test_basic();
    test_overrun();
    test_framing();
    test_parity();
    test_glitch();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
